// File: rtl/free_play_history_display_if.sv
// Free-play display bus: mode/keyboard inputs in, scanned seven-segment drive out.
// The slave side is the display block; the master side is whoever drives the keyboard inputs.
interface free_play_history_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic                  en;
    logic                  clr;
    logic [1:0]            octave;
    logic [2:0]            note;
    logic [NUM_DIGITS-1:0] seg_en;
    logic [7:0]            seg_outl;
    logic [7:0]            seg_outr;

    modport master (
        output en, clr, octave, note,
        input  seg_en, seg_outl, seg_outr
    );

    modport slave (
        input  en, clr, octave, note,
        output seg_en, seg_outl, seg_outr
    );
endinterface

// File: rtl/free_play_history_display.sv
// Free-play seven-segment display: "FP" label plus a history of recent notes,
// with a built-in two-bus digit scanner (left bus = upper half, right bus = lower half).
module free_play_history_display #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int CNT_W      = 17
) (
    input logic                        clk,
    input logic                        rst,
    free_play_history_display_if.slave bus
);
    localparam int HALF       = NUM_DIGITS / 2;
    localparam int HIST_DEPTH = (NUM_DIGITS - 2) / 2;
    localparam int IDX_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DIG_W      = IDX_W + 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);
    localparam logic [DIG_W-1:0] HALF_OFS = DIG_W'(HALF);

    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_P     = 8'hCE;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    function automatic logic [7:0] digit_glyph(input logic [2:0] n);
        logic [7:0] g;
        case (n)
            3'd0:    g = 8'hFC;
            3'd1:    g = 8'h60;
            3'd2:    g = 8'hDA;
            3'd3:    g = 8'hF2;
            3'd4:    g = 8'h66;
            3'd5:    g = 8'hB6;
            3'd6:    g = 8'hBE;
            default: g = 8'hE0;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] octave_glyph(input logic [1:0] o);
        logic [7:0] g;
        case (o)
            2'b10:   g = 8'h6E;
            2'b01:   g = 8'hEC;
            2'b00:   g = 8'h1C;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    logic [HIST_DEPTH-1:0] hist_v;
    logic [1:0]            hist_oct  [HIST_DEPTH];
    logic [2:0]            hist_note [HIST_DEPTH];
    logic [2:0]            note_q;

    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;

    logic                  push;
    logic                  live;
    logic [7:0]            glyph [NUM_DIGITS];
    logic [DIG_W-1:0]      r_sel;
    logic [DIG_W-1:0]      l_sel;
    logic [NUM_DIGITS-1:0] en_mask;

    // A push needs a note that differs from last cycle's, so holding a key
    // (or holding it through a clear) never pushes again.
    assign push = bus.en && (bus.note != 3'd0) && (bus.note != note_q);
    assign live = bus.en && (bus.note != 3'd0) && hist_v[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_v <= '0;
            note_q <= 3'd0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_oct[k]  <= 2'd0;
                hist_note[k] <= 3'd0;
            end
        end else begin
            note_q <= bus.note;
            if (bus.clr) begin
                hist_v <= '0;
            end else if (push) begin
                for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                    hist_v[k]    <= hist_v[k-1];
                    hist_oct[k]  <= hist_oct[k-1];
                    hist_note[k] <= hist_note[k-1];
                end
                hist_v[0]    <= 1'b1;
                hist_oct[0]  <= bus.octave;
                hist_note[0] <= bus.note;
            end
        end
    end

    // The scan keeps running while disabled so re-enabling resumes mid-cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            glyph[d] = GLYPH_BLANK;
        end
        glyph[NUM_DIGITS-1] = GLYPH_F;
        glyph[NUM_DIGITS-2] = GLYPH_P;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            if (hist_v[k]) begin
                glyph[2*k+1] = octave_glyph(hist_oct[k]);
                glyph[2*k]   = digit_glyph(hist_note[k]);
            end
        end
        if (live) begin
            glyph[0][0] = 1'b1;
        end
    end

    always_comb begin
        r_sel          = {1'b0, idx};
        l_sel          = r_sel + HALF_OFS;
        en_mask        = '0;
        en_mask[r_sel] = 1'b1;
        en_mask[l_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.seg_en   <= '0;
            bus.seg_outl <= 8'h00;
            bus.seg_outr <= 8'h00;
        end else if (!bus.en) begin
            bus.seg_en   <= '0;
            bus.seg_outl <= 8'h00;
            bus.seg_outr <= 8'h00;
        end else begin
            bus.seg_en   <= en_mask;
            bus.seg_outl <= glyph[l_sel];
            bus.seg_outr <= glyph[r_sel];
        end
    end
endmodule

// File: tb/tb_free_play_history_display.sv
// Bench for free_play_history_display: a cycle model predicts each registered output
// word one cycle ahead; directed checks pin the glyphs of known scenarios.
module tb_free_play_history_display;
    localparam int ND   = 8;
    localparam int HALF = ND / 2;
    localparam int HD   = (ND - 2) / 2;
    localparam int SDIV = 4;
    localparam int W    = ND + 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    free_play_history_display_if #(.NUM_DIGITS(ND)) bus ();

    free_play_history_display #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SDIV),
        .CNT_W     (17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    bit m_v    [HD];
    int m_oct  [HD];
    int m_note [HD];
    int m_nq;
    int m_div;
    int m_idx;
    int last_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_digit(input int n);
        case (n)
            0: return 8'hFC;
            1: return 8'h60;
            2: return 8'hDA;
            3: return 8'hF2;
            4: return 8'h66;
            5: return 8'hB6;
            6: return 8'hBE;
            default: return 8'hE0;
        endcase
    endfunction

    function automatic logic [7:0] m_letter(input int o);
        case (o)
            2: return 8'h6E;
            1: return 8'hEC;
            0: return 8'h1C;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] m_glyph(input int d);
        int k;
        if (d == ND - 1) return 8'h8E;
        if (d == ND - 2) return 8'hCE;
        k = d / 2;
        if (!m_v[k]) return 8'h00;
        if (d % 2 == 1) return m_letter(m_oct[k]);
        return m_digit(m_note[k]);
    endfunction

    function automatic logic [W-1:0] m_out();
        logic [ND-1:0] se;
        logic [7:0]    gl;
        logic [7:0]    gr;
        if (!bus.en) return '0;
        se = '0;
        se[HALF + m_idx] = 1'b1;
        se[m_idx] = 1'b1;
        gl = m_glyph(HALF + m_idx);
        gr = m_glyph(m_idx);
        if (m_idx == 0 && bus.note != 3'd0 && m_v[0]) gr[0] = 1'b1;
        return {se, gl, gr};
    endfunction

    task automatic m_advance();
        bit push;
        push = bus.en && (int'(bus.note) != 0) && (int'(bus.note) != m_nq);
        if (bus.clr) begin
            for (int k = 0; k < HD; k++) m_v[k] = 1'b0;
        end else if (push) begin
            for (int k = HD - 1; k > 0; k--) begin
                m_v[k]    = m_v[k-1];
                m_oct[k]  = m_oct[k-1];
                m_note[k] = m_note[k-1];
            end
            m_v[0]    = 1'b1;
            m_oct[0]  = int'(bus.octave);
            m_note[0] = int'(bus.note);
        end
        m_nq = int'(bus.note);
        if (m_div == SDIV - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % HALF;
        end else begin
            m_div++;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < HD; k++) begin
            m_v[k] = 1'b0;
            m_oct[k] = 0;
            m_note[k] = 0;
        end
        m_nq = 0;
        m_div = 0;
        m_idx = 0;
        exp_q.delete();
    endtask

    // One clock: predict, advance the model, then compare what the DUT registered.
    task automatic step();
        logic [W-1:0] e;
        exp_q.push_back(m_out());
        last_idx = m_idx;
        m_advance();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = exp_q.pop_front();
            check("out", 32'({bus.seg_en, bus.seg_outl, bus.seg_outr}), 32'(e));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the outputs just registered belong to scan slot want.
    task automatic wait_idx(input int want);
        int n;
        n = 0;
        step();
        while (last_idx != want && n < 64) begin
            step();
            n++;
        end
        if (last_idx != want) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idx: slot %0d not reached, got %0d", want, last_idx);
        end
    endtask

    task automatic press(input int o, input int n, input int hold);
        bus.octave = 2'(o);
        bus.note = 3'(n);
        steps(hold);
        bus.note = 3'd0;
        steps(2);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.clr = 1'b0;
        bus.octave = 2'b11;
        bus.note = 3'd0;
        last_idx = 0;
        m_reset();

        // reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 32'({bus.seg_en, bus.seg_outl, bus.seg_outr}), 32'h0);
        rst = 1'b1;
        m_reset();

        // first scan slot and wrap
        step();
        check("first_slot", 32'(bus.seg_en), 32'h11);
        check("first_outl", 32'(bus.seg_outl), 32'h00);
        steps(20);

        // empty history: FP label
        wait_idx(3);
        check("idx3_en", 32'(bus.seg_en), 32'h88);
        check("idx3_F", 32'(bus.seg_outl), 32'h8E);
        check("idx3_r", 32'(bus.seg_outr), 32'h00);
        wait_idx(2);
        check("idx2_P", 32'(bus.seg_outl), 32'hCE);

        // held key: one push, live marker while held
        bus.octave = 2'b10;
        bus.note = 3'd5;
        steps(10);
        wait_idx(0);
        check("held_B7", 32'(bus.seg_outr), 32'hB7);
        wait_idx(1);
        check("held_H", 32'(bus.seg_outr), 32'h6E);
        check("pair2_blank", 32'(bus.seg_outl), 32'h00);
        bus.note = 3'd0;
        wait_idx(0);
        check("rel_B6", 32'(bus.seg_outr), 32'hB6);

        // history ordering and overflow
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        press(0, 3, 3);
        bus.note = 3'd1;
        steps(3);
        bus.note = 3'd7;
        steps(3);
        bus.note = 3'd0;
        wait_idx(0);
        check("hist_L7", 32'(bus.seg_outr), 32'hE0);
        check("hist_d4_3", 32'(bus.seg_outl), 32'hF2);
        wait_idx(1);
        check("hist_d5_L", 32'(bus.seg_outl), 32'h1C);
        wait_idx(2);
        check("hist_d2_1", 32'(bus.seg_outr), 32'h60);
        press(0, 2, 3);
        wait_idx(0);
        check("drop_oldest", 32'(bus.seg_outl), 32'h60);
        check("newest_2", 32'(bus.seg_outr), 32'hDA);

        // clear beats a simultaneous push; held key not re-pushed
        bus.note = 3'd4;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        steps(10);
        wait_idx(0);
        check("clr_r", 32'(bus.seg_outr), 32'h00);
        check("clr_l", 32'(bus.seg_outl), 32'h00);
        bus.note = 3'd0;
        steps(2);
        bus.note = 3'd4;
        steps(3);
        wait_idx(0);
        check("repress_live", 32'(bus.seg_outr), 32'h67);
        bus.note = 3'd0;
        wait_idx(0);
        check("repress_rel", 32'(bus.seg_outr), 32'h66);
        wait_idx(1);
        check("single_entry", 32'(bus.seg_outl), 32'h00);

        // disabled: outputs dark, no pushes
        bus.en = 1'b0;
        steps(5);
        bus.note = 3'd6;
        steps(8);
        bus.note = 3'd0;
        steps(7);
        check("en_off", 32'({bus.seg_en, bus.seg_outl, bus.seg_outr}), 32'h0);
        bus.en = 1'b1;
        wait_idx(1);
        check("en_back", 32'(bus.seg_outr), 32'h1C);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) bus.note = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bus.octave = 2'($urandom_range(0, 3));
            bus.en = ($urandom_range(0, 9) != 0);
            bus.clr = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.en = 1'b1;
        bus.clr = 1'b0;
        bus.note = 3'd0;
        steps(2);

        // reset mid-scan with a full history
        press(2, 1, 2);
        press(2, 2, 2);
        press(2, 3, 2);
        wait_idx(2);
        check("pre_rst_d2", 32'(bus.seg_outr), 32'hDA);
        #3;
        rst = 1'b0;
        #1;
        check("rst_async", 32'({bus.seg_en, bus.seg_outl, bus.seg_outr}), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_low", 32'({bus.seg_en, bus.seg_outl, bus.seg_outr}), 32'h0);
        end
        rst = 1'b1;
        m_reset();
        step();
        check("post_rst_en", 32'(bus.seg_en), 32'h11);
        check("post_rst_r", 32'(bus.seg_outr), 32'h00);
        wait_idx(1);
        check("post_rst_hist", 32'(bus.seg_outr), 32'h00);
        steps(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
